// File: rtl/tokenflow_pkg.sv
// Shared constants for the tokenflow sequence generator: FSM state encoding,
// generation-mode codes and the default ack synchroniser depth.
package tokenflow_pkg;

  localparam logic [1:0] ST_WAIT_LOW = 2'd0;
  localparam logic [1:0] ST_CALC     = 2'd1;
  localparam logic [1:0] ST_PRESENT  = 2'd2;

  localparam logic [1:0] MODE_PRONIC = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_SCALE  = 2'd2;
  localparam logic [1:0] MODE_BYPASS = 2'd3;

  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/tokenflow_seq_gen_mul.sv
// Iterative LSB-first shift-add multiplier, product truncated mod 2^W.
// The first partial product is folded into the load so done pulses in the W-th cycle after start.
module shift_add_mul #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  acc;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [CW-1:0] cnt;
  logic          run;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      acc  <= b[0] ? a : '0;
      a_sh <= a << 1;
      b_sh <= b >> 1;
      cnt  <= CW'(W - 1);
      run  <= 1'b1;
    end else if (run) begin
      if (cnt != '0) begin
        acc  <= acc + (b_sh[0] ? a_sh : '0);
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt - 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done = run && (cnt == '0);
  assign p    = acc;

endmodule

// File: rtl/tokenflow_seq_gen.sv
// Token generator on a 4-phase bundled-data req/ack channel; each token is
// x*(x+1), x*x, x*coef or x, computed by the shift-add multiplier.
module tokenflow_seq_gen
  import tokenflow_pkg::*;
#(
  parameter int W           = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic [W-1:0] coef,
  output logic         out_req,
  output logic [W-1:0] out_data,
  input  logic         out_ack,
  output logic         busy
);

  logic [1:0]             state;
  logic [W-1:0]           x;
  logic [1:0]             mode_r;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   ack_s;
  logic                   ack_low;
  logic                   start;
  logic [W-1:0]           b_sel;
  logic                   mul_done;
  logic [W-1:0]           mul_p;

  assign ack_s = ack_sync[SYNC_STAGES-1];
  // The chain is cleared by reset, so ack_s only reflects the pin once it has
  // flushed through; otherwise a receiver holding ack high would be missed.
  assign ack_low = sync_fill[SYNC_STAGES-1] && !ack_s;
  assign busy    = (state == ST_CALC);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    b_sel = x;
    start = (state == ST_WAIT_LOW) && ack_low && (mode != MODE_BYPASS);
    case (mode)
      MODE_PRONIC: b_sel = x + 1'b1;
      MODE_SQUARE: b_sel = x;
      MODE_SCALE:  b_sel = coef;
      default:     b_sel = x;
    endcase
  end

  shift_add_mul #(.W(W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (x),
    .b     (b_sel),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_WAIT_LOW;
      x         <= '0;
      mode_r    <= MODE_PRONIC;
      out_req   <= 1'b0;
      out_data  <= '0;
      ack_sync  <= '0;
      sync_fill <= '0;
    end else begin
      ack_sync  <= {ack_sync[SYNC_STAGES-2:0], out_ack};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      case (state)
        ST_WAIT_LOW: begin
          if (ack_low) begin
            mode_r <= mode;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (mode_r == MODE_BYPASS) begin
            out_data <= x;
            out_req  <= 1'b1;
            state    <= ST_PRESENT;
          end else if (mul_done) begin
            out_data <= mul_p;
            out_req  <= 1'b1;
            state    <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack_s) begin
            out_req <= 1'b0;
            x       <= x + 1'b1;
            state   <= ST_WAIT_LOW;
          end
        end
        default: state <= ST_WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_tokenflow_seq_gen.sv
// Directed bench for tokenflow_seq_gen: a W=16 instance for modes, handshake
// and reset behaviour, and a W=4 instance for wrap-around.
module tb_tokenflow_seq_gen;

  localparam int W  = 16;
  localparam int W4 = 4;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [W-1:0]  coef;
  logic          loop16;
  logic          ack_drv;
  logic          out_ack;
  logic          out_req;
  logic [W-1:0]  out_data;
  logic          busy;

  logic          reset4;
  logic [1:0]    mode4;
  logic [W4-1:0] coef4;
  logic          out_req4;
  logic [W4-1:0] out_data4;
  logic          busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign out_ack = loop16 ? out_req : ack_drv;
  assign coef4   = '0;

  tokenflow_seq_gen #(.W(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .coef     (coef),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .busy     (busy)
  );

  tokenflow_seq_gen #(.W(W4), .SYNC_STAGES(S)) dut4 (
    .clk      (clk),
    .reset    (reset4),
    .mode     (mode4),
    .coef     (coef4),
    .out_req  (out_req4),
    .out_data (out_data4),
    .out_ack  (out_req4),
    .busy     (busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next rising edge of out_req on the selected instance, then
  // checks the token and, when exp_calc >= 0, the number of busy cycles.
  task automatic get_token(input bit sel, input string tag, input int exp, input int exp_calc);
    int n;
    int calc;
    n = 0;
    while ((sel ? out_req4 : out_req) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    calc = 0;
    n = 0;
    while ((sel ? out_req4 : out_req) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if ((sel ? busy4 : busy) === 1'b1) calc++;
    end
    check({tag, " req"}, 32'(sel ? out_req4 : out_req), 32'd1);
    check(tag, sel ? 32'(out_data4) : 32'(out_data), 32'(exp));
    if (exp_calc >= 0) check({tag, " calc"}, 32'(calc), 32'(exp_calc));
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd1);
  endtask

  task automatic rst16(input logic [1:0] m);
    @(negedge clk);
    reset = 1'b1;
    mode  = m;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0]  exp_p0 [6]  = '{0, 2, 6, 12, 20, 30};
    logic [W-1:0]  exp_p1 [5]  = '{0, 1, 4, 9, 16};
    logic [W-1:0]  exp_p2 [4]  = '{0, 3, 6, 9};
    logic [W4-1:0] exp_w4 [18] = '{0, 2, 6, 12, 4, 14, 10, 8, 8, 10, 14, 4, 12, 6, 2, 0, 0, 2};
    int  n;
    bit  stable;

    reset   = 1'b1;
    mode    = 2'd0;
    coef    = '0;
    loop16  = 1'b1;
    ack_drv = 1'b0;
    reset4  = 1'b1;
    mode4   = 2'd0;

    repeat (2) @(negedge clk);
    check("reset out_req", 32'(out_req), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) get_token(1'b0, $sformatf("pronic x=%0d", i), int'(exp_p0[i]), W);

    rst16(2'd1);
    for (int i = 0; i < 5; i++) get_token(1'b0, $sformatf("square x=%0d", i), int'(exp_p1[i]), W);

    coef = 16'd3;
    rst16(2'd2);
    for (int i = 0; i < 4; i++) get_token(1'b0, $sformatf("scale3 x=%0d", i), int'(exp_p2[i]), W);
    wait_busy("busy before coef change");
    coef = 16'd5;
    get_token(1'b0, "coef change ignored x=4", 12, -1);
    get_token(1'b0, "coef 5 x=5", 25, W);

    // Receiver holds ack high across reset release.
    loop16  = 1'b0;
    ack_drv = 1'b1;
    rst16(2'd0);
    repeat (10) @(negedge clk);
    check("ack high blocks req", 32'(out_req), 32'd0);
    check("ack high blocks busy", 32'(busy), 32'd0);
    ack_drv = 1'b0;
    n = 0;
    while (out_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ack drop latency", 32'(n), 32'(S + 1 + W));
    check("ack drop data", 32'(out_data), 32'd0);

    // Slow receiver: data must hold while ack stays low.
    stable = 1'b1;
    repeat (17) begin
      @(negedge clk);
      if (out_data !== 16'd0 || out_req !== 1'b1) stable = 1'b0;
    end
    check("slow receiver stable", 32'(stable), 32'd1);
    ack_drv = 1'b1;
    n = 0;
    while (out_req !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("slow receiver req drop", 32'(out_req), 32'd0);
    check("slow receiver data after drop", 32'(out_data), 32'd0);
    ack_drv = 1'b0;
    get_token(1'b0, "manual x=1", 2, W);

    // Reset while out_req is high.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset in present req", 32'(out_req), 32'd0);
    check("reset in present data", 32'(out_data), 32'd0);
    reset  = 1'b0;
    loop16 = 1'b1;
    get_token(1'b0, "restart after present reset", 0, W);

    // Reset in the middle of CALC.
    wait_busy("busy before calc reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset in calc busy", 32'(busy), 32'd0);
    check("reset in calc req", 32'(out_req), 32'd0);
    check("reset in calc data", 32'(out_data), 32'd0);
    reset = 1'b0;
    get_token(1'b0, "restart after calc reset x=0", 0, W);
    get_token(1'b0, "restart after calc reset x=1", 2, W);

    // W=4 wrap-around, pronic then bypass.
    reset4 = 1'b0;
    for (int i = 0; i < 18; i++) get_token(1'b1, $sformatf("w4 pronic #%0d", i), int'(exp_w4[i]), W4);
    @(negedge clk);
    reset4 = 1'b1;
    mode4  = 2'd3;
    repeat (2) @(negedge clk);
    reset4 = 1'b0;
    for (int i = 0; i < 18; i++) get_token(1'b1, $sformatf("w4 bypass #%0d", i), i % 16, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tokenflow_seq_gen.md
Name: tokenflow_seq_gen

Overview:
- Clocked, parametrised successor to the tokenflow x*(x+1) generator.
- Emits an unbounded stream of tokens on a 4-phase bundled-data req/ack output channel.
- Each token is computed by an iterative shift-add multiplier. The generation mode is run-time selectable.
- The ack input may come from an unsynchronised off-chip pin, so it is synchronised internally.
- Sits directly behind the top-level pin wrapper: out_data/out_req go to uo_out/uio_out, out_ack comes from ui_in.

Parameters:
- W, 16: token/data width in bits; also the multiplier iteration count.
- SYNC_STAGES, 2: flops in the out_ack synchroniser (minimum 2).

Ports:
- clk, input, 1: the single clock.
- reset, input, 1: synchronous, active-high reset.
- mode, input, 2: generation mode; 0 = x*(x+1), 1 = x*x, 2 = x*coef, 3 = x (bypass).
- coef, input, W: multiplier operand used in mode 2.
- out_req, output, 1: 4-phase request; high means out_data is valid.
- out_data, output, W: token value; bundled with out_req.
- out_ack, input, 1: 4-phase acknowledge; asynchronous, synchronised internally.
- busy, output, 1: high while in CALC.

Behaviour:
- Reset: synchronous, takes effect on the edge where reset=1.
  - out_req=0, out_data=0, busy=0.
  - Counter x=0, synchroniser flops cleared, state=WAIT_LOW.
  - Reset asserted mid-handshake drops out_req on that same edge. The sequence restarts at x=0.
- ack_s is out_ack after SYNC_STAGES flops. The FSM uses only ack_s.
- WAIT_LOW:
  - out_req=0. Stay while ack_s=1.
  - When ack_s=0: sample mode and coef into registers, load the multiplier, go to CALC.
  - Consequence: a receiver holding ack high at reset release blocks the first token.
- CALC, modes 0-2:
  - Operands: a=x. b = x+1 mod 2^W (mode 0), x (mode 1), or coef_r (mode 2).
  - Shift-add runs LSB-first over b, exactly W cycles; busy=1 throughout.
  - Product is truncated to the low W bits (mod 2^W).
- CALC, mode 3: exactly 1 cycle, result = x.
- CALC exit: on the edge ending the last CALC cycle, out_data <= result, out_req <= 1, state=PRESENT.
- PRESENT:
  - out_req=1, out_data held stable.
  - On ack_s=1: out_req <= 0, x <= x+1 mod 2^W, state=WAIT_LOW.
- Data stability: out_data changes only on the CALC->PRESENT edge. It therefore stays stable from out_req rise until after the receiver's ack falls.
- Mode/coef changes: changes during CALC/PRESENT are ignored; they apply to the next token only.
- Wrap (x = 2^W-1):
  - Mode 0: b=0, so the token is 0.
  - Mode 1: the token is 1.
  - Next x=0.
- Cycle count with ack looped back to req: per token = W CALC cycles + SYNC_STAGES+1 cycles (PRESENT) + SYNC_STAGES+1 cycles (WAIT_LOW).
- Hard invariant: never more than one outstanding token.
- A glitch-free ack assumption is not required; only the synchronised level matters.

Decomposition:
- Shared package tokenflow_pkg:
  - FSM state encoding WAIT_LOW/CALC/PRESENT.
  - Mode constants MODE_PRONIC=0, MODE_SQUARE=1, MODE_SCALE=2, MODE_BYPASS=3.
  - SYNC_STAGES default.
- One sub-module, shift_add_mul #(W):
  - Inputs: clk, reset, start, a, b. Outputs: done, p[W-1:0].
  - start is a pulse. done pulses in the W-th cycle after start. The result is truncated mod 2^W.
- The synchroniser and FSM stay inline in tokenflow_seq_gen.

Test Plan:
- Mode 0, ack tied to req, reset released after 2 cycles: data captured on each req rise = 0, 2, 6, 12, 20, 30. Each token's req rise is exactly W cycles after its WAIT_LOW exit.
- Mode 1 -> 0, 1, 4, 9, 16.
- Mode 2, coef=3 -> 0, 3, 6, 9. Switching coef to 5 while busy=1 leaves the current token unchanged; the next token uses 5.
- W=4, mode 0, run through wrap: ..., 13*14 mod 16=6, 14*15 mod 16=2, 15*0=0, then 0 (x=0), 2. Mode 3 at W=4: 15 followed by 0.
- out_ack held at 1 across reset release: out_req stays 0. After ack drops, out_req rises SYNC_STAGES+1+W cycles later with data 0.
- Reset asserted while out_req=1 and mid-CALC: out_req=0 and out_data=0 after that edge. The stream restarts at 0. Slow receiver (ack delayed 17 cycles): out_data is held constant throughout.
